bit_serial_adder: RTL and testbench
===================================

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; sampled only on rising edge of clk.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on the accepted start edge.
REQ-006 b  input  WIDTH  operand B; captured on the accepted start edge.
REQ-007 cin  input  1  carry-in; captured on the accepted start edge.
REQ-008 busy  output  1  high while state is RUN.
REQ-009 done  output  1  single-cycle pulse, high while state is DONE.
REQ-010 sum  output  WIDTH  registered result; valid from the DONE cycle until the next accepted start.
REQ-011 cout  output  1  registered carry-out; same validity as sum.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE with start=1 SHALL, at that edge, latch a, b and cin into internal registers, clear the bit counter and the sum register, and go to RUN.
REQ-014 IDLE with start=0 SHALL remain in IDLE and hold sum and cout.
REQ-015 Each RUN cycle SHALL add one bit pair, LSB first, through a single full-adder cell.
- s = a_bit ^ b_bit ^ c.
- c_next = majority(a_bit, b_bit, c).
- The carry register is initialised to the latched cin.
REQ-016 At each RUN edge, s SHALL be written into sum bit [counter]; the carry register SHALL take c_next; the counter SHALL increment.
REQ-017 RUN SHALL last exactly WIDTH cycles; the edge that processes bit WIDTH-1 SHALL load cout with the final c_next and go to DONE.
REQ-018 DONE SHALL last exactly one cycle, with done=1, then return unconditionally to IDLE.
REQ-019 Latency: with start accepted at edge T, done SHALL be high during the cycle after edge T+WIDTH, and sum/cout SHALL be valid in that same cycle.
REQ-020 start SHALL be ignored in RUN and DONE; no re-latch, no restart, no effect on the result.
REQ-021 Changes on a, b or cin after the accepted start edge SHALL NOT affect the result.
REQ-022 Arithmetic: {cout, sum} SHALL equal a + b + cin, computed modulo 2^(WIDTH+1) with no truncation.
REQ-023 The counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL NOT wrap during RUN.
REQ-024 busy and done SHALL never be high simultaneously, and SHALL both be low in IDLE.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force state IDLE, with busy=0, done=0, sum=0, cout=0, counter=0, carry register=0 and operand registers=0.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; the next addition SHALL need a fresh start after rst_n returns high.
REQ-027 start high in the same edge as rst_n=0 SHALL be ignored.

Verification
REQ-028 WIDTH=8, inputs a=0x00, b=0x00, cin=0, start pulse at edge T.
- Expected: busy high for 8 cycles, done high one cycle after edge T+8, sum=0x00, cout=0.
REQ-029 WIDTH=8, inputs a=0xFF, b=0x01, cin=0.
- Expected: sum=0x00, cout=1.
- Repeat with a=0xA5, b=0x5A, cin=1; expected: sum=0x00, cout=1.
REQ-030 WIDTH=8, a=0x3C, b=0x0F, cin=0, start accepted.
- During RUN: hold start=1 and change the inputs to a=0xFF, b=0xFF.
- Expected: sum=0x4B, cout=0, and exactly one done pulse.
REQ-031 WIDTH=8, start an addition, then assert rst_n=0 at the 4th RUN edge.
- Expected: next cycle IDLE, busy=0, sum=0x00, cout=0, and no done pulse.
- A following start with a=0x01, b=0x02, cin=0 SHALL yield sum=0x03.
REQ-032 WIDTH=2, sweep all 32 combinations of a, b and cin back-to-back.
- Assert start in the IDLE cycle right after each done.
- Check {cout, sum} against a+b+cin.
- Check the start-to-done spacing is exactly WIDTH+1 edges every time.

Source files
------------

// File: rtl/bit_serial_adder.sv
// -----------------------------------------------------------------------------
// bit_serial_adder
//
// Purpose:
//   Adds two WIDTH-bit operands plus a carry-in using a single full-adder cell,
//   one bit pair per clock, LSB first. The operands and the carry-in are
//   captured when a start request is accepted in IDLE. After WIDTH RUN cycles
//   the block spends one cycle in DONE, raising done, with {cout, sum} equal to
//   a + b + cin. It then returns to IDLE, where sum and cout are held until the
//   next accepted start.
//
// Parameters:
//   WIDTH  operand width in bits, legal range 2..32 (default 8)
//
// Ports:
//   clk    in   1      sole clock, rising edge
//   rst_n  in   1      synchronous active-low reset, sampled on the rising edge
//   start  in   1      begin an addition; only looked at in IDLE
//   a      in   WIDTH  operand A, captured on the accepted start edge
//   b      in   WIDTH  operand B, captured on the accepted start edge
//   cin    in   1      carry-in, captured on the accepted start edge
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse while in DONE
//   sum    out  WIDTH  registered result, valid from DONE until the next start
//   cout   out  1      registered carry-out, same validity as sum
//
// Latency:
//   Start accepted at edge T -> done is high in the cycle after edge T+WIDTH.
// -----------------------------------------------------------------------------
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // The counter needs one bit more than an index into the operand. It has
    // to reach WIDTH after the last RUN edge without wrapping.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    // Catch an illegal width while the design is being elaborated.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("bit_serial_adder: WIDTH must be in 2..32");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]   b_q,     b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   sum_q,   sum_d;
    logic               cout_q,  cout_d;

    // Full-adder cell signals
    logic               a_bit;
    logic               b_bit;
    logic               s_bit;
    logic               c_next;

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable this block writes gets a default first. That
        // way no path through the case statement leaves a value unassigned,
        // and so no latch is inferred.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        a_bit   = 1'b0;
        b_bit   = 1'b0;

        // Select the operand bit pair addressed by the counter. The operand
        // registers stay untouched during RUN, so later input changes on a,
        // b or cin cannot reach the result.
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_bit = a_q[i];
                b_bit = b_q[i];
            end
        end

        // Single full-adder cell
        s_bit  = a_bit ^ b_bit ^ carry_q;
        c_next = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        sum_d[i] = s_bit;
                    end
                end
                carry_d = c_next;
                cnt_d   = cnt_q + CNT_W'(1);
                // The final bit produces the carry-out, and this edge moves
                // the block to DONE.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cout_d  = c_next;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers with synchronous active-low reset
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: flops are updated with non-blocking assignments. Every
        // register then samples its _d value from before the edge, whatever
        // order the statements appear in.
        if (!rst_n) begin
            state_q <= IDLE;
            // NOTE: the operand registers are individual flops, not a memory
            // array, so they take part in reset like the rest of the state.
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Both strobes are decoded from the state register. They are therefore
    // glitch-free and can never be high at the same time.
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_adder
//
// Self-checking bench for bit_serial_adder. One instance uses WIDTH=8 and
// covers the directed, random, input-disturbance and reset-abort cases. A
// second instance uses WIDTH=2 and runs the exhaustive back-to-back sweep.
// Expected results come from plain integer arithmetic a + b + cin.
// Inputs are driven, and outputs sampled, on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_bit_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    // WIDTH=8 instance
    logic       start8;
    logic [7:0] a8, b8;
    logic       cin8;
    logic       busy8, done8;
    logic [7:0] sum8;
    logic       cout8;

    // WIDTH=2 instance
    logic       start2;
    logic [1:0] a2, b2;
    logic       cin2;
    logic       busy2, done2;
    logic [1:0] sum2;
    logic       cout2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    bit_serial_adder #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .cin   (cin2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .cout  (cout2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One addition on the WIDTH=8 instance. With disturb set, start stays high
    // through RUN and DONE, and the inputs switch to da/db/~cv after the start
    // edge. Neither change may alter the result or produce a second done.
    task automatic run_add8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic cv, input bit disturb,
                            input logic [7:0] da, input logic [7:0] db);
        logic [8:0] exp;
        int         cyc;
        int         busy_cyc;
        exp = 9'(av) + 9'(bv) + 9'(cv);
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        @(negedge clk);                       // start edge T has passed
        if (disturb) begin
            a8 = da; b8 = db; cin8 = ~cv;
        end else begin
            start8 = 1'b0;
        end
        cyc = 0;
        busy_cyc = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            if (busy8 === 1'b1) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(8));
        check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(8));
        check({tag, "_busy_low_in_done"}, 64'(busy8), 64'(0));
        check({tag, "_sum"}, 64'(sum8), 64'(exp[7:0]));
        check({tag, "_cout"}, 64'(cout8), 64'(exp[8]));
        start8 = 1'b0;
        @(negedge clk);                       // back in IDLE
        check({tag, "_single_done"}, 64'(done8), 64'(0));
        check({tag, "_idle_busy"}, 64'(busy8), 64'(0));
        check({tag, "_sum_hold"}, 64'({cout8, sum8}), 64'(exp));
    endtask

    initial begin
        logic [2:0] exp2;
        logic [7:0] ra, rb;
        logic       rc;
        int         cyc;
        int         k;

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy8", 64'(busy8), 64'(0));
        check("rst_done8", 64'(done8), 64'(0));
        check("rst_sum8",  64'({cout8, sum8}), 64'(0));
        check("rst_busy2", 64'({busy2, done2}), 64'(0));
        check("rst_sum2",  64'({cout2, sum2}), 64'(0));
        rst_n = 1'b1;

        // Directed cases
        run_add8("zero",  8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        run_add8("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00);
        run_add8("a5_5a", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 8'h00);
        run_add8("hold",  8'h3C, 8'h0F, 1'b0, 1'b1, 8'hFF, 8'hFF);

        // Random operands, half of them with inputs disturbed during RUN
        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            run_add8("rand", ra, rb, rc, 1'(i % 2), 8'($urandom), 8'($urandom));
        end

        // Reset mid-RUN: leave a nonzero result behind first
        run_add8("pre_abort", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);                       // after edge T
        start8 = 1'b0;
        repeat (3) begin
            @(negedge clk);                   // after T+1, T+2, T+3
            check("abort_no_done_run", 64'(done8), 64'(0));
        end
        rst_n = 1'b0;                         // takes effect at T+4
        start8 = 1'b1;                        // must be ignored under reset
        @(negedge clk);
        check("abort_busy", 64'(busy8), 64'(0));
        check("abort_done", 64'(done8), 64'(0));
        check("abort_sum",  64'({cout8, sum8}), 64'(0));
        @(negedge clk);
        check("rst_start_ignored", 64'({busy8, done8}), 64'(0));
        rst_n = 1'b1;
        start8 = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 64'({busy8, done8}), 64'(0));
        run_add8("post_abort", 8'h01, 8'h02, 1'b0, 1'b0, 8'h00, 8'h00);

        // WIDTH=2 exhaustive sweep. Each start is raised in the IDLE cycle
        // right after the previous done.
        @(negedge clk);
        for (k = 0; k < 32; k++) begin
            a2 = k[1:0];
            b2 = k[3:2];
            cin2 = k[4];
            exp2 = 3'(a2) + 3'(b2) + 3'(cin2);
            start2 = 1'b1;
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
                start2 = 1'b0;
            end while (done2 !== 1'b1 && cyc < 20);
            check("w2_spacing", 64'(cyc), 64'(3));
            check("w2_result", 64'({cout2, sum2}), 64'(exp2));
            @(negedge clk);                   // IDLE cycle after done
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
